thermocouple_spi_responder: RTL and testbench
=============================================

Name: thermocouple_spi_responder

Overview:
Behavioural SPI slave that stands in for the MAX31855-style thermocouple converter. It periodically snapshots the supplied temperature and fault values and serialises them as a 32-bit frame on MISO when the Thermocouple reader's SPI master selects it. Used in simulation benches and on FPGA loopback builds in place of the physical sensor. All logic runs in the clk domain; SPI inputs are oversampled.

Parameters:
CONV_CYCLES, 400, clk cycles per conversion (100 ms at 4 kHz clk); minimum 2.
CNT_W, 16, conversion counter width; 2^CNT_W > CONV_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
cs_n  input  1  SPI chip select, active low, asynchronous to clk.
sck  input  1  SPI clock (mode 0), asynchronous to clk.
tc_temp_in  input  14  thermocouple temperature, 0.25 °C/LSB, two's complement.
junction_temp_in  input  12  cold-junction temperature, 0.0625 °C/LSB.
fault_in  input  3  {SCV, SCG, OC} fault flags.
miso  output  1  serial data out.
miso_oe  output  1  MISO drive enable; 1 only while selected.
frame_done  output  1  one-cycle pulse after the 32nd bit has shifted.
snapshot_valid  output  1  1 once at least one conversion has completed.

Behaviour:
- Reset (rst=0, async): miso=0, miso_oe=0, frame_done=0, snapshot_valid=0, snapshot=0, shift reg=0, bit count=0, conv counter=0, state=IDLE. Sync flops reset to cs_n=1, sck=0.
- Sync: cs_n and sck each pass through a 2-flop synchroniser, plus a third flop for edge detection. Edges are detected on the synchronised signals. MISO changes 3 clk after the physical edge. The SCK high and low times must each be at least 4 clk.
- Frame format, MSB first: [31:18]=tc, [17]=0, [16]=|fault, [15:4]=junction, [3]=0, [2:0]=fault_in.
- IDLE (cs_n high):
  - Conv counter increments each clk.
  - At CONV_CYCLES-1: capture the inputs into the snapshot as a formatted 32-bit word, set snapshot_valid=1 (sticky until reset), and reset the counter to 0.
  - miso_oe=0, miso=0. SCK edges are ignored.
- IDLE -> SHIFT on the synchronised cs_n falling edge:
  - Load the shift reg from the snapshot, bit count=0, miso=bit31, miso_oe=1.
  - The conv counter clears and holds while selected.
  - If a capture and the cs_n fall coincide, the fall wins: capture is suppressed and the old snapshot is loaded.
- SHIFT:
  - On each synchronised SCK falling edge, shift left by 1 with 0 shifted in, and increment bit count; miso = new MSB.
  - The first falling edge presents bit30.
  - When bit count reaches 31 and a further falling edge occurs (bit0 has been presented and sampled), pulse frame_done for 1 clk and go to TAIL.
  - Rising SCK edges do not change state.
- TAIL: miso=0, miso_oe=1. Further SCK edges are ignored.
- SHIFT or TAIL -> IDLE on the synchronised cs_n rising edge:
  - miso_oe=0, miso=0, conv counter restarts from 0.
  - Deselect in SHIFT aborts the frame: no frame_done, and the snapshot is unchanged.
- The snapshot never changes while selected, so a frame is always coherent.
- Reset asserted mid-frame returns immediately to reset values; MISO is released.

Test Plan:
- Reset, then hold cs_n=1 for CONV_CYCLES+5 clk with tc=14'h0190, junction=12'h190, fault=0 -> snapshot_valid rises at clk CONV_CYCLES; a subsequent 32-clock frame reads 32'h06401900; frame_done pulses once.
- Same temperatures with fault_in=3'b001 -> frame reads 32'h06411901 (bits 16 and 0 set).
- Read before the first conversion completes -> frame reads 32'h00000000, snapshot_valid=0, miso_oe=1 throughout selection.
- Change the inputs to tc=14'h3FFC mid-frame -> the current frame still returns the old word; the next frame, after CONV_CYCLES deselected, returns the new tc in [31:18].
- Raise cs_n after 10 SCK cycles -> miso_oe=0 within 3 clk, no frame_done; the next full frame returns the complete snapshot from bit31.
- Pull rst low while in SHIFT at bit 20 -> miso=0, miso_oe=0, snapshot_valid=0 immediately (asynchronously); after release, the first frame reads 0.

Source files
------------

// File: rtl/thermocouple_spi_responder_if.sv
// SPI bus between a thermocouple reader (master) and the behavioural
// MAX31855-style responder (slave).
interface thermocouple_spi_responder_if;
    logic cs_n;
    logic sck;
    logic miso;
    logic miso_oe;

    modport master (output cs_n, output sck, input miso, input miso_oe);
    modport slave  (input cs_n, input sck, output miso, output miso_oe);
endinterface

// File: rtl/thermocouple_spi_responder.sv
// Behavioural MAX31855-style SPI slave: periodically snapshots temperature and
// fault inputs and shifts the formatted 32-bit word out MSB first on MISO.
module thermocouple_spi_responder #(
    parameter int CONV_CYCLES = 400,
    parameter int CNT_W       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    thermocouple_spi_responder_if.slave       spi,
    input  logic [13:0]                       tc_temp_in,
    input  logic [11:0]                       junction_temp_in,
    input  logic [2:0]                        fault_in,
    output logic                              frame_done,
    output logic                              snapshot_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] TAIL  = 2'd2;

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);

    logic [1:0]       state;
    logic [2:0]       cs_sync;
    logic [2:0]       sck_sync;
    logic [31:0]      snapshot;
    logic [31:0]      shift_reg;
    logic [4:0]       bit_cnt;
    logic [CNT_W-1:0] conv_cnt;
    logic             miso_q;
    logic             oe_q;
    logic             cs_fall;
    logic             cs_rise;
    logic             sck_fall;
    logic [31:0]      capture_word;

    // Two synchroniser stages plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync  <= 3'b111;
            sck_sync <= 3'b000;
        end else begin
            cs_sync  <= {cs_sync[1:0], spi.cs_n};
            sck_sync <= {sck_sync[1:0], spi.sck};
        end
    end

    assign cs_fall  = cs_sync[2] & ~cs_sync[1];
    assign cs_rise  = ~cs_sync[2] & cs_sync[1];
    assign sck_fall = sck_sync[2] & ~sck_sync[1];

    assign capture_word = {tc_temp_in, 1'b0, |fault_in, junction_temp_in, 1'b0, fault_in};

    assign spi.miso    = miso_q;
    assign spi.miso_oe = oe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            snapshot       <= '0;
            snapshot_valid <= 1'b0;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            conv_cnt       <= '0;
            miso_q         <= 1'b0;
            oe_q           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    miso_q <= 1'b0;
                    oe_q   <= 1'b0;
                    // A select arriving on the capture cycle wins, so the frame stays coherent.
                    if (cs_fall) begin
                        shift_reg <= snapshot;
                        bit_cnt   <= '0;
                        miso_q    <= snapshot[31];
                        oe_q      <= 1'b1;
                        conv_cnt  <= '0;
                        state     <= SHIFT;
                    end else if (conv_cnt == CONV_LAST) begin
                        snapshot       <= capture_word;
                        snapshot_valid <= 1'b1;
                        conv_cnt       <= '0;
                    end else begin
                        conv_cnt <= conv_cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        miso_q   <= 1'b0;
                        oe_q     <= 1'b0;
                        conv_cnt <= '0;
                        state    <= IDLE;
                    end else if (sck_fall) begin
                        if (bit_cnt == 5'd31) begin
                            frame_done <= 1'b1;
                            miso_q     <= 1'b0;
                            state      <= TAIL;
                        end else begin
                            shift_reg <= {shift_reg[30:0], 1'b0};
                            bit_cnt   <= bit_cnt + 5'd1;
                            miso_q    <= shift_reg[30];
                        end
                    end
                end
                TAIL: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        oe_q     <= 1'b0;
                        conv_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    miso_q <= 1'b0;
                    oe_q   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thermocouple_spi_responder.sv
// Directed plus randomized bench for thermocouple_spi_responder, checked
// against a word-level model of the snapshot/frame behaviour.
module tb_thermocouple_spi_responder;

    localparam int CONV_CYCLES = 50;
    localparam int CNT_W       = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] tc;
    logic [11:0] junc;
    logic [2:0]  fault;
    logic        frame_done;
    logic        snapshot_valid;

    thermocouple_spi_responder_if spi_bus();

    thermocouple_spi_responder #(
        .CONV_CYCLES(CONV_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (spi_bus),
        .tc_temp_in      (tc),
        .junction_temp_in(junc),
        .fault_in        (fault),
        .frame_done      (frame_done),
        .snapshot_valid  (snapshot_valid)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int done_pulses = 0;
    int pulses_at_start;

    always @(posedge clk) if (frame_done === 1'b1) done_pulses++;

    logic [31:0] model_snap;
    logic        model_valid;
    logic [31:0] rx_word;
    logic        oe_seen_low;

    // Frame word built arithmetically from the field positions.
    function automatic logic [31:0] expected_frame(input logic [13:0] t, input logic [11:0] j,
                                                   input logic [2:0] f);
        int unsigned w;
        w = t;
        w = w * 262144 + ((f != 3'd0) ? 65536 : 0) + 16 * int'(j) + int'(f);
        return 32'(w);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [13:0] t, input logic [11:0] j, input logic [2:0] f);
        @(negedge clk);
        tc    = t;
        junc  = j;
        fault = f;
    endtask

    // A long enough deselected stretch guarantees a capture of the current inputs.
    task automatic idle(input int n);
        spi_bus.cs_n = 1'b1;
        repeat (n) @(negedge clk);
        if (n >= CONV_CYCLES + 8) begin
            model_snap  = expected_frame(tc, junc, fault);
            model_valid = 1'b1;
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        spi_bus.cs_n = 1'b0;
        repeat (5) @(negedge clk);
        rx_word         = '0;
        oe_seen_low     = 1'b0;
        pulses_at_start = done_pulses;
    endtask

    task automatic shift_bits(input int n);
        for (int i = 0; i < n; i++) begin
            rx_word = {rx_word[30:0], spi_bus.miso};
            if (spi_bus.miso_oe !== 1'b1) oe_seen_low = 1'b1;
            spi_bus.sck = 1'b1;
            repeat (5) @(negedge clk);
            spi_bus.sck = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic end_frame();
        spi_bus.cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic full_frame(input string tag);
        start_frame();
        checkOutput({tag, "_valid"}, 32'(snapshot_valid), 32'(model_valid));
        shift_bits(32);
        checkOutput({tag, "_word"}, rx_word, model_snap);
        checkOutput({tag, "_oe_held"}, 32'(oe_seen_low), 32'd0);
        checkOutput({tag, "_done_pulses"}, 32'(done_pulses - pulses_at_start), 32'd1);
        end_frame();
        checkOutput({tag, "_oe_released"}, 32'(spi_bus.miso_oe), 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        spi_bus.cs_n = 1'b1;
        spi_bus.sck  = 1'b0;
        tc           = 14'h0190;
        junc         = 12'h190;
        fault        = 3'b000;
        model_snap   = '0;
        model_valid  = 1'b0;
        #12;
        checkOutput("reset_miso", 32'(spi_bus.miso), 32'd0);
        checkOutput("reset_oe", 32'(spi_bus.miso_oe), 32'd0);
        checkOutput("reset_done", 32'(frame_done), 32'd0);
        checkOutput("reset_valid", 32'(snapshot_valid), 32'd0);

        // First conversion completes on clock CONV_CYCLES after reset release.
        @(negedge clk);
        rst = 1'b1;
        repeat (CONV_CYCLES - 1) @(posedge clk);
        #1 checkOutput("valid_before_conv", 32'(snapshot_valid), 32'd0);
        @(posedge clk);
        #1 checkOutput("valid_after_conv", 32'(snapshot_valid), 32'd1);
        repeat (6) @(negedge clk);
        model_snap  = expected_frame(tc, junc, fault);
        model_valid = 1'b1;
        start_frame();
        shift_bits(32);
        checkOutput("first_frame_word", rx_word, 32'h06401900);
        checkOutput("first_frame_done", 32'(done_pulses - pulses_at_start), 32'd1);
        end_frame();

        applyStimulus(14'h0190, 12'h190, 3'b001);
        idle(CONV_CYCLES + 10);
        start_frame();
        shift_bits(32);
        checkOutput("fault_frame_word", rx_word, 32'h06411901);
        end_frame();

        // Inputs changing mid-frame must not disturb the word being shifted.
        start_frame();
        shift_bits(10);
        tc = 14'h3FFC;
        shift_bits(22);
        checkOutput("midchange_old_word", rx_word, model_snap);
        end_frame();
        idle(CONV_CYCLES + 10);
        full_frame("midchange_new");
        checkOutput("midchange_new_tc", 32'(rx_word[31:18]), 32'h3FFC);

        start_frame();
        shift_bits(10);
        spi_bus.cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_oe", 32'(spi_bus.miso_oe), 32'd0);
        checkOutput("abort_miso", 32'(spi_bus.miso), 32'd0);
        checkOutput("abort_no_done", 32'(done_pulses - pulses_at_start), 32'd0);
        repeat (3) @(negedge clk);
        full_frame("after_abort");

        for (int k = 0; k < 6; k++) begin
            applyStimulus(14'($urandom), 12'($urandom), 3'($urandom));
            idle(CONV_CYCLES + 10 + int'($urandom_range(0, 20)));
            if ($urandom_range(0, 2) == 0) begin
                start_frame();
                shift_bits(int'($urandom_range(1, 30)));
                end_frame();
                idle(5);
            end
            full_frame($sformatf("rand%0d", k));
        end

        // Asynchronous reset in the middle of a frame.
        start_frame();
        shift_bits(20);
        rst = 1'b0;
        #1;
        checkOutput("midreset_miso", 32'(spi_bus.miso), 32'd0);
        checkOutput("midreset_oe", 32'(spi_bus.miso_oe), 32'd0);
        checkOutput("midreset_valid", 32'(snapshot_valid), 32'd0);
        model_snap   = '0;
        model_valid  = 1'b0;
        spi_bus.cs_n = 1'b1;
        spi_bus.sck  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        full_frame("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
